if_fetch_unit: RTL and testbench

Instruction-fetch (F) stage of the five-stage MIPS pipeline. It owns the PC and drives the address into the instruction memory. It captures the returned instruction word into the IF/ID pipeline register. It applies stall, flush and branch/jump/jr redirects coming back from the D stage, and flags illegal fetch addresses.

---
 rtl/if_fetch_unit_if.sv | 27 ++
 rtl/if_fetch_unit.sv | 76 +++++++
 tb/tb_if_fetch_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, D-stage redirect/hazard
// controls, and the IF/ID pipeline register outputs.
interface if_fetch_unit_if;
  logic [31:0] imaddr;
  logic [31:0] instr_f;
  logic        stall;
  logic        flush;
  logic [1:0]  npc_sel;
  logic [31:0] br_target;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc8_d;
  logic        adel_d;
  logic [31:0] fetch_cnt;

  modport slave (
    input  instr_f, stall, flush, npc_sel, br_target, j_index, jr_target,
    output imaddr, instr_d, pc_d, pc8_d, adel_d, fetch_cnt
  );

  modport master (
    output instr_f, stall, flush, npc_sel, br_target, j_index, jr_target,
    input  imaddr, instr_d, pc_d, pc8_d, adel_d, fetch_cnt
  );
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: PC register, next-PC select, fetch address
// check and the IF/ID pipeline register.
module if_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_WORDS = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  if_fetch_unit_if.slave bus
);

  localparam logic [31:0] PC_LIMIT = PC_RESET + 32'(4 * IM_WORDS);

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc4_d;
  logic        illegal;

  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic [31:0] pc8_q;
  logic        adel_q;
  logic [31:0] cnt_q;

  assign pc4_d   = pc_q + 32'd4;
  assign illegal = (pc[1:0] != 2'b00) || (pc < PC_RESET) || (pc >= PC_LIMIT);

  // Jump targets take their upper nibble from the delay-slot PC held in D.
  always_comb begin
    pc_next = pc + 32'd4;
    case (bus.npc_sel)
      2'b01:   pc_next = bus.br_target;
      2'b10:   pc_next = {pc4_d[31:28], bus.j_index, 2'b00};
      2'b11:   pc_next = bus.jr_target;
      default: pc_next = pc + 32'd4;
    endcase
  end

  // Stall alone governs the PC, so a flush during a stall still holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= PC_RESET;
    end else if (!bus.stall) begin
      pc <= pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      pc8_q   <= '0;
      adel_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (bus.flush) begin
      instr_q <= '0;
      pc_q    <= '0;
      pc8_q   <= '0;
      adel_q  <= 1'b0;
    end else if (!bus.stall) begin
      instr_q <= illegal ? 32'd0 : bus.instr_f;
      pc_q    <= pc;
      pc8_q   <= pc + 32'd8;
      adel_q  <= illegal;
      cnt_q   <= cnt_q + 32'd1;
    end
  end

  assign bus.imaddr    = pc;
  assign bus.instr_d   = instr_q;
  assign bus.pc_d      = pc_q;
  assign bus.pc8_d     = pc8_q;
  assign bus.adel_d    = adel_q;
  assign bus.fetch_cnt = cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized
// redirect/stall/flush traffic checked against a behavioural fetch model.
module tb_if_fetch_unit;
  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          WORDS = 1024;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_mis = 0;
  bit   checking = 1'b0;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.PC_RESET(BASE), .IM_WORDS(WORDS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Instruction memory; out-of-range addresses return junk that must never reach IF/ID.
  logic [31:0] mem [WORDS];
  logic [31:0] ioff;
  assign ioff = bus.imaddr - BASE;
  always_comb begin
    if (ioff < 32'(4 * WORDS)) bus.instr_f = mem[ioff[11:2]];
    else                       bus.instr_f = 32'hBAD0_0000 ^ bus.imaddr;
  end

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pc_d, m_pc8, m_cnt;
  logic        m_adel;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = BASE; m_instr = 0; m_pc_d = 0; m_pc8 = 0; m_adel = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    longint      p;
    bit          bad;
    logic [31:0] tgt;
    p   = longint'(m_pc);
    bad = (p % 4 != 0) || (p < longint'(BASE)) || (p >= longint'(BASE) + 4 * WORDS);
    case (bus.npc_sel)
      2'd1:    tgt = bus.br_target;
      2'd2:    tgt = ((m_pc_d + 32'd4) & 32'hF000_0000) | (32'(bus.j_index) * 4);
      2'd3:    tgt = bus.jr_target;
      default: tgt = m_pc + 32'd4;
    endcase
    if (bus.flush) begin
      m_instr = 0; m_pc_d = 0; m_pc8 = 0; m_adel = 0;
    end else if (!bus.stall) begin
      m_instr = bad ? 32'd0 : mem[int'((p - longint'(BASE)) / 4)];
      m_pc_d  = m_pc;
      m_pc8   = m_pc + 32'd8;
      m_adel  = bad;
      m_cnt   = m_cnt + 32'd1;
    end
    if (!bus.stall) m_pc = tgt;
  endtask

  always @(posedge clk) if (rst_n) model_edge();
  always @(negedge rst_n) model_reset();

  always @(negedge clk) begin
    if (checking) begin
      chk("imaddr",    bus.imaddr,          m_pc);
      chk("instr_d",   bus.instr_d,         m_instr);
      chk("pc_d",      bus.pc_d,            m_pc_d);
      chk("pc8_d",     bus.pc8_d,           m_pc8);
      chk("adel_d",    32'(bus.adel_d),     32'(m_adel));
      chk("fetch_cnt", bus.fetch_cnt,       m_cnt);
    end
  end

  task automatic drive(input bit st, input bit fl, input logic [1:0] sel,
                       input logic [31:0] br, input logic [25:0] ji, input logic [31:0] jr);
    bus.stall = st; bus.flush = fl; bus.npc_sel = sel;
    bus.br_target = br; bus.j_index = ji; bus.jr_target = jr;
  endtask

  task automatic cyc(input bit st, input bit fl, input logic [1:0] sel,
                     input logic [31:0] br, input logic [25:0] ji, input logic [31:0] jr);
    drive(st, fl, sel, br, ji, jr);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] legal_addr();
    return BASE + 32'($urandom_range(0, WORDS - 1)) * 4;
  endfunction

  initial begin
    logic [31:0] r_br, r_jr;
    logic [25:0] r_ji;
    bit r_st, r_fl;
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    model_reset();
    rst_n = 1'b0;
    drive(0, 0, 2'd0, 0, 0, 0);
    @(negedge clk); #1;
    chk("rst_imaddr",  bus.imaddr,    32'h0000_3000);
    chk("rst_instr_d", bus.instr_d,   32'h0);
    chk("rst_cnt",     bus.fetch_cnt, 32'h0);
    checking = 1'b1;
    rst_n = 1'b1;

    // Free-running fetch
    cyc(0, 0, 2'd0, 0, 0, 0);
    chk("run1_imaddr", bus.imaddr, 32'h0000_3004);
    chk("run1_instr",  bus.instr_d, mem[0]);
    chk("run1_pc8",    bus.pc8_d, 32'h0000_3008);
    cyc(0, 0, 2'd0, 0, 0, 0);
    chk("run2_instr",  bus.instr_d, mem[1]);
    cyc(0, 0, 2'd0, 0, 0, 0);
    chk("run3_imaddr", bus.imaddr, 32'h0000_300C);
    chk("run3_instr",  bus.instr_d, mem[2]);
    chk("run3_pc8",    bus.pc8_d, 32'h0000_3010);
    chk("run3_cnt",    bus.fetch_cnt, 32'd3);

    // Stall two cycles; a redirect presented during stall is dropped
    cyc(1, 0, 2'd1, 32'h0000_3100, 0, 0);
    cyc(1, 0, 2'd0, 0, 0, 0);
    chk("stall_imaddr", bus.imaddr, 32'h0000_300C);
    chk("stall_pc_d",   bus.pc_d, 32'h0000_3008);
    chk("stall_cnt",    bus.fetch_cnt, 32'd3);
    cyc(0, 0, 2'd0, 0, 0, 0);
    chk("unstall_imaddr", bus.imaddr, 32'h0000_3010);
    chk("unstall_cnt",    bus.fetch_cnt, 32'd4);

    // Branch: delay slot at 0x3010 still latched
    cyc(0, 0, 2'd1, 32'h0000_3040, 0, 0);
    chk("br_imaddr", bus.imaddr, 32'h0000_3040);
    chk("br_slot",   bus.pc_d, 32'h0000_3010);

    // Jump with pc_d = 0x3020
    cyc(0, 0, 2'd3, 0, 0, 32'h0000_3020);
    cyc(0, 0, 2'd0, 0, 0, 0);
    chk("j_pre_pc_d", bus.pc_d, 32'h0000_3020);
    cyc(0, 0, 2'd2, 0, 26'h0000C10, 0);
    chk("j_imaddr", bus.imaddr, 32'h0000_3040);

    // Illegal jr targets
    cyc(0, 0, 2'd3, 0, 0, 32'h0000_3002);
    cyc(0, 0, 2'd3, 0, 0, 32'h0000_2FFC);
    chk("mis_adel",  32'(bus.adel_d), 32'd1);
    chk("mis_instr", bus.instr_d, 32'h0);
    chk("mis_pc_d",  bus.pc_d, 32'h0000_3002);
    cyc(0, 0, 2'd3, 0, 0, 32'h0000_5000);
    chk("low_adel",  32'(bus.adel_d), 32'd1);
    chk("low_pc_d",  bus.pc_d, 32'h0000_2FFC);
    cyc(0, 0, 2'd0, 0, 0, 0);
    chk("high_adel",   32'(bus.adel_d), 32'd1);
    chk("high_pc_d",   bus.pc_d, 32'h0000_5000);
    chk("high_imaddr", bus.imaddr, 32'h0000_5004);

    // Back to legal space, then stall+flush
    cyc(0, 0, 2'd3, 0, 0, 32'h0000_3000);
    cyc(0, 0, 2'd0, 0, 0, 0);
    cyc(1, 1, 2'd1, 32'h0000_3200, 0, 0);
    chk("sf_imaddr", bus.imaddr, 32'h0000_3004);
    chk("sf_instr",  bus.instr_d, 32'h0);
    chk("sf_pc_d",   bus.pc_d, 32'h0);
    chk("sf_pc8",    bus.pc8_d, 32'h0);
    cyc(0, 1, 2'd0, 0, 0, 0);
    chk("fl_imaddr", bus.imaddr, 32'h0000_3008);

    // Wrap-around of PC+4 / PC+8
    cyc(0, 0, 2'd3, 0, 0, 32'hFFFF_FFFC);
    cyc(0, 0, 2'd0, 0, 0, 0);
    chk("wrap_imaddr", bus.imaddr, 32'h0000_0000);
    chk("wrap_pc8",    bus.pc8_d, 32'h0000_0004);

    // Randomized traffic with a mid-run asynchronous reset
    for (int n = 0; n < 4000; n++) begin
      r_st = ($urandom_range(0, 99) < 20);
      r_fl = ($urandom_range(0, 99) < 12);
      r_br = ($urandom_range(0, 9) == 0) ? $urandom : legal_addr();
      r_jr = ($urandom_range(0, 9) == 0) ? $urandom : legal_addr();
      r_ji = ($urandom_range(0, 9) == 0) ? 26'($urandom) : 26'(legal_addr() >> 2);
      if (n == 2000) begin
        drive(r_st, r_fl, 2'($urandom_range(0, 3)), r_br, r_ji, r_jr);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_imaddr", bus.imaddr, 32'h0000_3000);
        chk("arst_instr",  bus.instr_d, 32'h0);
        chk("arst_pc_d",   bus.pc_d, 32'h0);
        chk("arst_pc8",    bus.pc8_d, 32'h0);
        chk("arst_adel",   32'(bus.adel_d), 32'h0);
        chk("arst_cnt",    bus.fetch_cnt, 32'h0);
        @(negedge clk); #1;
        rst_n = 1'b1;
      end else begin
        cyc(r_st, r_fl, 2'($urandom_range(0, 3)), r_br, r_ji, r_jr);
      end
    end

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
